// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries. Flush beats push and pop; head is read
// combinationally so the datapath sees it in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with a single-outstanding req/ack memory port feeding a prefetch FIFO.
// Define IFETCH_BYPASS_EN to forward an acked word straight to the outputs when the FIFO is empty.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int            CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   fpc_reg, fpc_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic          mem_req_reg, mem_req_next;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  entry_t        fifo_head;
  entry_t        push_entry;
  logic          ack_xfer;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          has_head;
  logic [31:0]   redirect_target;
  logic [31:0]   fpc_inc;
  logic          unused_low_bits;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  assign fpc_inc         = fpc_reg + PC_INC;
  assign ack_xfer        = mem_req_reg && mem_ack;
  assign has_head        = (fifo_count != '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = (state_reg == WAIT) && ack_xfer && !has_head && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is consumed in the same cycle never occupies a slot.
  assign push        = (state_reg == WAIT) && ack_xfer && !redirect_valid && !(bypass && consume);
  assign pop         = consume && has_head && !redirect_valid;
  assign count_after = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
  assign push_entry  = '{pc: fpc_reg, inst: mem_rdata};

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fpc_reg      <= RESET_PC;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fpc_reg      <= fpc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fpc_next      = fpc_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    case (state_reg)
      IDLE: begin
        if (count_after < LIMIT) begin
          state_next    = WAIT;
          mem_req_next  = 1'b1;
          mem_addr_next = redirect_valid ? redirect_target : fpc_reg;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // Without an ack the request is still live and must be drained with its stale address.
          if (ack_xfer) begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end else begin
            state_next = DISCARD;
          end
        end else if (ack_xfer) begin
          fpc_next = fpc_inc;
          if (count_after < LIMIT) begin
            mem_addr_next = fpc_inc;
          end else begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (ack_xfer) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
    if (redirect_valid) fpc_next = redirect_target;
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign inst_valid = has_head || bypass;
  assign inst_out   = bypass ? mem_rdata : (has_head ? fifo_head.inst : 32'd0);
  assign inst_pc    = bypass ? fpc_reg   : (has_head ? fifo_head.pc   : 32'd0);

endmodule
